// File: rtl/pulse_interval_meter.sv
// Pulse interval meter.
// Measures the number of SYS_CLK cycles between a start edge on PULSE_A
// and a stop edge on PULSE_B. Both pulses are asynchronous to SYS_CLK and
// go through identical synchronizers, so their equal latencies cancel out
// of the measured interval. A three-state FSM (IDLE / ARMED / COUNT)
// controls the interval counter. RESULT/OVF are updated with a one-cycle
// VALID pulse when an interval completes. A one-cycle TMO pulse reports
// an interval abandoned because it reached TIMEOUT_LIM.

// Synchronizes one asynchronous pulse line and turns the selected edge
// into a one-cycle event.
module pulse_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          FALL        = 1'b0
) (
  input  logic SYS_CLK,
  input  logic A_RESET,
  input  logic i_pulse,
  output logic o_event
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic                   w_level;

  assign w_level = r_sync[SYNC_STAGES-1];

  // Synchronizer chain followed by one delay flop for edge comparison.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values; blocking here would collapse the chain into one stage.
  always_ff @(posedge SYS_CLK or posedge A_RESET) begin
    if (A_RESET) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pulse};
      r_dly  <= w_level;
    end
  end

  // Edge selection: rising edge by default, falling edge when FALL is set.
  assign o_event = FALL ? (r_dly & ~w_level) : (~r_dly & w_level);

endmodule

// Top level: edge detectors, measurement FSM, counter and result registers.
module pulse_interval_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          A_FALL      = 1'b0,
  parameter bit          B_FALL      = 1'b0
) (
  input  logic             SYS_CLK,
  input  logic             A_RESET,
  input  logic             PULSE_A,
  input  logic             PULSE_B,
  input  logic             ARM,
  input  logic             CONT,
  input  logic             ABORT,
  input  logic [CNT_W-1:0] TIMEOUT_LIM,
  output logic [CNT_W-1:0] RESULT,
  output logic             OVF,
  output logic             VALID,
  output logic             TMO,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_COUNT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_result;
  logic [CNT_W-1:0] w_result_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_tmo;
  logic             w_tmo_nxt;

  logic             w_ev_a;
  logic             w_ev_b;
  logic             w_cnt_sat;
  logic             w_timeout;
  state_t           w_after_meas;

  pulse_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .FALL        (A_FALL)
  ) u_edge_a (
    .SYS_CLK (SYS_CLK),
    .A_RESET (A_RESET),
    .i_pulse (PULSE_A),
    .o_event (w_ev_a)
  );

  pulse_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .FALL        (B_FALL)
  ) u_edge_b (
    .SYS_CLK (SYS_CLK),
    .A_RESET (A_RESET),
    .i_pulse (PULSE_B),
    .o_event (w_ev_b)
  );

  // The counter sticks at all-ones; that value doubles as the overflow flag.
  assign w_cnt_sat    = (r_cnt == CNT_MAX);
  // TIMEOUT_LIM is compared live every cycle, so a change applies at once.
  assign w_timeout    = (TIMEOUT_LIM != '0) && (r_cnt == TIMEOUT_LIM);
  assign w_after_meas = CONT ? ST_ARMED : ST_IDLE;

  // Next-state, counter and result logic; ABORT beats evB, evB beats timeout.
  // NOTE: every output of this block gets a default first; a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_ovf_nxt    = r_ovf;
    w_valid_nxt  = 1'b0;
    w_tmo_nxt    = 1'b0;

    if (ABORT) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_cnt_nxt = '0;
          if (ARM) begin
            w_state_nxt = ST_ARMED;
          end
        end

        ST_ARMED: begin
          // A stop event while armed is meaningless; only a start matters,
          // even when both arrive in the same cycle.
          w_cnt_nxt = '0;
          if (w_ev_a) begin
            w_state_nxt = ST_COUNT;
            w_cnt_nxt   = CNT_ONE;
          end
        end

        ST_COUNT: begin
          if (w_ev_b) begin
            w_result_nxt = r_cnt;
            w_ovf_nxt    = w_cnt_sat;
            w_valid_nxt  = 1'b1;
            w_state_nxt  = w_after_meas;
            w_cnt_nxt    = '0;
          end else if (w_timeout) begin
            w_tmo_nxt   = 1'b1;
            w_state_nxt = w_after_meas;
            w_cnt_nxt   = '0;
          end else if (!w_cnt_sat) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, counter and output registers; reset clears everything at once.
  always_ff @(posedge SYS_CLK or posedge A_RESET) begin
    if (A_RESET) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
      r_ovf    <= w_ovf_nxt;
      r_valid  <= w_valid_nxt;
      r_tmo    <= w_tmo_nxt;
    end
  end

  assign RESULT = r_result;
  assign OVF    = r_ovf;
  assign VALID  = r_valid;
  assign TMO    = r_tmo;
  assign BUSY   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Testbench for pulse_interval_meter: table-driven directed rows, hand
// sequences for multi-cycle corners, and a randomized run against an
// event-timestamp reference model.
module tb_pulse_interval_meter;

  localparam int SYNC  = 2;
  localparam int LAT   = SYNC + 1;   // drive-to-VALID offset beyond the interval
  localparam int MAX16 = 65535;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        pa    = 1'b0;
  logic        pb    = 1'b0;
  logic        arm   = 1'b0;
  logic        cont  = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] tlim  = '0;
  logic [3:0]  tlim4 = '0;

  logic [15:0] res0;
  logic        ovf0, valid0, tmo0, busy0;
  logic [3:0]  res4;
  logic        ovf4, valid4, tmo4, busy4;
  logic [15:0] resf;
  logic        ovff, validf, tmof, busyf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pulse_interval_meter #(.CNT_W(16), .SYNC_STAGES(SYNC), .A_FALL(0), .B_FALL(0)) u_dut (
    .SYS_CLK(clk), .A_RESET(rst), .PULSE_A(pa), .PULSE_B(pb), .ARM(arm), .CONT(cont),
    .ABORT(abort), .TIMEOUT_LIM(tlim), .RESULT(res0), .OVF(ovf0), .VALID(valid0),
    .TMO(tmo0), .BUSY(busy0));

  pulse_interval_meter #(.CNT_W(4), .SYNC_STAGES(SYNC), .A_FALL(0), .B_FALL(0)) u_dut4 (
    .SYS_CLK(clk), .A_RESET(rst), .PULSE_A(pa), .PULSE_B(pb), .ARM(arm), .CONT(cont),
    .ABORT(abort), .TIMEOUT_LIM(tlim4), .RESULT(res4), .OVF(ovf4), .VALID(valid4),
    .TMO(tmo4), .BUSY(busy4));

  pulse_interval_meter #(.CNT_W(16), .SYNC_STAGES(SYNC), .A_FALL(1), .B_FALL(1)) u_dutf (
    .SYS_CLK(clk), .A_RESET(rst), .PULSE_A(pa), .PULSE_B(pb), .ARM(arm), .CONT(cont),
    .ABORT(abort), .TIMEOUT_LIM(tlim), .RESULT(resf), .OVF(ovff), .VALID(validf),
    .TMO(tmof), .BUSY(busyf));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for VALID or TMO on the main (sel=0) or falling-edge DUT.
  task automatic watch(input int sel, input int max_cyc, input int base,
                       output bit gv, output bit gt, output int lat);
    bit v, t;
    gv  = 1'b0;
    gt  = 1'b0;
    lat = -1;
    for (int n = 1; n <= max_cyc; n++) begin
      step();
      v = (sel == 0) ? valid0 : validf;
      t = (sel == 0) ? tmo0   : tmof;
      if (v || t) begin
        gv  = v;
        gt  = t;
        lat = base + n;
        break;
      end
    end
  endtask

  task automatic clean();
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
  endtask

  task automatic arm_up();
    arm = 1'b1;
    step();
    step();
  endtask

  // ---------------- reference model for the random phase ----------------
  typedef struct {
    int res;
    bit ovf;
  } meas_t;

  meas_t exp_q[$];
  bit    m_counting = 1'b0;
  int    m_t0       = 0;
  int    m_lim      = 0;
  int    exp_tmo    = 0;
  bit    mon_en     = 1'b0;
  int    tmo_cnt    = 0;
  int    both_cnt   = 0;
  int    f_valid_cnt = 0;

  // Interval = stop time minus start time, capped at the counter maximum.
  task automatic model(input int c, input bit eva, input bit evb);
    int    iv;
    meas_t m;
    if (m_counting) begin
      iv = c - m_t0;
      if (iv > MAX16) iv = MAX16;
      if (evb) begin
        m.res = iv;
        m.ovf = (iv >= MAX16);
        exp_q.push_back(m);
        m_counting = 1'b0;
      end else if (m_lim != 0 && iv == m_lim) begin
        exp_tmo++;
        m_counting = 1'b0;
      end
    end else if (eva) begin
      m_counting = 1'b1;
      m_t0       = c;
    end
  endtask

  always @(negedge clk) begin
    if (validf) f_valid_cnt++;
    if (mon_en) begin
      meas_t e;
      if (valid0 && tmo0) both_cnt++;
      if (tmo0) tmo_cnt++;
      if (valid0) begin
        check("rand VALID expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rand RESULT", res0, e.res);
          check("rand OVF", ovf0, e.ovf);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // ---------------- directed table ----------------
  typedef struct {
    int gap;        // A-to-B distance in cycles, -1 = no B edge
    int lim;        // TIMEOUT_LIM
    bit exp_valid;
    int exp_result;
    bit exp_ovf;
    bit exp_tmo;
  } row_t;

  initial begin
    row_t rows [0:7];
    bit   gv, gt;
    int   lat;
    int   lim;

    rows[0] = '{100,   0, 1'b1, 100, 1'b0, 1'b0};
    rows[1] = '{  1,   0, 1'b1,   1, 1'b0, 1'b0};
    rows[2] = '{  7,   0, 1'b1,   7, 1'b0, 1'b0};
    rows[3] = '{ -1,  20, 1'b0,   7, 1'b0, 1'b1};
    rows[4] = '{  5,   5, 1'b1,   5, 1'b0, 1'b0};
    rows[5] = '{  6,   5, 1'b0,   5, 1'b0, 1'b1};
    rows[6] = '{250,   0, 1'b1, 250, 1'b0, 1'b0};
    rows[7] = '{  3, 300, 1'b1,   3, 1'b0, 1'b0};

    // Reset state.
    step();
    step();
    check("reset RESULT", res0, 0);
    check("reset OVF", ovf0, 0);
    check("reset VALID/TMO", {valid0, tmo0}, 0);
    check("reset BUSY", busy0, 0);
    check("reset dut4 outputs", {res4, ovf4, valid4, tmo4, busy4}, 0);
    check("reset dutf outputs", {resf, ovff, validf, tmof, busyf}, 0);
    rst = 1'b0;
    step();
    step();

    // ABORT together with ARM in IDLE keeps IDLE.
    abort = 1'b1;
    arm   = 1'b1;
    repeat (3) step();
    check("abort+arm idle BUSY", busy0, 0);
    abort = 1'b0;
    arm   = 1'b0;
    step();

    foreach (rows[i]) begin
      tlim = rows[i].lim[15:0];
      arm_up();
      check($sformatf("row%0d armed BUSY", i), busy0, 1);
      pa  = 1'b1;
      arm = 1'b0;
      if (rows[i].gap >= 0) begin
        repeat (rows[i].gap) step();
        pb = 1'b1;
        watch(0, 400, rows[i].gap, gv, gt, lat);
      end else begin
        watch(0, 400, 0, gv, gt, lat);
      end
      check($sformatf("row%0d VALID", i), gv, rows[i].exp_valid);
      check($sformatf("row%0d TMO", i), gt, rows[i].exp_tmo);
      check($sformatf("row%0d RESULT", i), res0, rows[i].exp_result);
      check($sformatf("row%0d OVF", i), ovf0, rows[i].exp_ovf);
      check($sformatf("row%0d latency", i), lat,
            LAT + (rows[i].exp_valid ? rows[i].gap : rows[i].lim));
      step();
      check($sformatf("row%0d pulse width", i), {valid0, tmo0}, 0);
      check($sformatf("row%0d idle BUSY", i), busy0, 0);
      pa = 1'b0;
      pb = 1'b0;
      repeat (6) step();
    end

    // Timeout with CONT=1 returns to ARMED and measures the next pair.
    clean();
    cont = 1'b1;
    tlim = 16'd20;
    arm_up();
    arm = 1'b0;
    pa  = 1'b1;
    watch(0, 60, 0, gv, gt, lat);
    check("cont TMO", gt, 1);
    check("cont TMO no VALID", gv, 0);
    check("cont TMO latency", lat, LAT + 20);
    check("cont TMO RESULT unchanged", res0, 3);
    step();
    check("cont TMO once", tmo0, 0);
    check("cont rearmed BUSY", busy0, 1);
    pa = 1'b0;
    repeat (3) step();
    pa = 1'b1;
    repeat (7) step();
    pb = 1'b1;
    watch(0, 60, 7, gv, gt, lat);
    check("cont second VALID", gv, 1);
    check("cont second RESULT", res0, 7);
    check("cont second latency", lat, LAT + 7);
    step();
    check("cont still armed BUSY", busy0, 1);
    cont = 1'b0;
    tlim = '0;
    pa   = 1'b0;
    pb   = 1'b0;
    clean();
    check("abort from armed BUSY", busy0, 0);
    repeat (4) step();

    // Saturation on the 4-bit instance, same stimulus measured by the 16-bit one.
    clean();
    arm_up();
    pa  = 1'b1;
    arm = 1'b0;
    repeat (40) step();
    pb = 1'b1;
    watch(0, 60, 40, gv, gt, lat);
    check("sat main RESULT", res0, 40);
    check("sat dut4 VALID", valid4, 1);
    check("sat dut4 RESULT", res4, 15);
    check("sat dut4 OVF", ovf4, 1);
    pa = 1'b0;
    pb = 1'b0;
    repeat (6) step();

    // A and B in the same cycle while armed: counting starts, B ignored.
    clean();
    arm_up();
    pa  = 1'b1;
    pb  = 1'b1;
    arm = 1'b0;
    step();
    pb = 1'b0;
    step();
    pb = 1'b1;
    watch(0, 40, 2, gv, gt, lat);
    check("coincident VALID", gv, 1);
    check("coincident RESULT", res0, 2);
    check("coincident latency", lat, LAT + 2);
    pa = 1'b0;
    pb = 1'b0;
    repeat (6) step();

    // Falling-edge instance: rising edges alone give nothing, falling pair gives 12.
    clean();
    f_valid_cnt = 0;
    arm_up();
    pa  = 1'b1;
    arm = 1'b0;
    repeat (12) step();
    pb = 1'b1;
    watch(0, 40, 12, gv, gt, lat);
    check("rising pair main RESULT", res0, 12);
    repeat (4) step();
    check("rising edges dutf VALID count", f_valid_cnt, 0);
    check("dutf armed BUSY", busyf, 1);
    pa = 1'b0;
    repeat (12) step();
    pb = 1'b0;
    watch(2, 40, 12, gv, gt, lat);
    check("falling VALID", gv, 1);
    check("falling RESULT", resf, 12);
    check("falling latency", lat, LAT + 12);
    repeat (4) step();

    // ABORT at count 30.
    clean();
    arm_up();
    pa  = 1'b1;
    arm = 1'b0;
    repeat (32) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort BUSY", busy0, 0);
    pb = 1'b1;
    watch(0, 20, 0, gv, gt, lat);
    check("abort no VALID/TMO", {gv, gt}, 0);
    pa = 1'b0;
    pb = 1'b0;
    repeat (6) step();

    // Reset at count 30: outputs clear immediately, nothing after release.
    arm_up();
    pa  = 1'b1;
    arm = 1'b0;
    repeat (32) step();
    #3;
    rst = 1'b1;
    #1;
    check("async reset RESULT", res0, 0);
    check("async reset OVF/VALID/TMO/BUSY", {ovf0, valid0, tmo0, busy0}, 0);
    step();
    rst = 1'b0;
    pb  = 1'b1;
    watch(0, 20, 0, gv, gt, lat);
    check("after reset no VALID/TMO", {gv, gt}, 0);
    check("after reset BUSY", busy0, 0);
    pa = 1'b0;
    pb = 1'b0;
    repeat (6) step();

    // Randomized run, CONT=1, checked against the timestamp model.
    lim   = $urandom_range(60, 30);
    m_lim = lim;
    tlim  = lim[15:0];
    cont  = 1'b1;
    arm   = 1'b1;
    repeat (3) step();
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      bit eva, evb;
      step();
      eva = 1'b0;
      evb = 1'b0;
      if ($urandom_range(7, 0) == 0) begin
        pa  = ~pa;
        eva = pa;
      end
      if ($urandom_range(7, 0) == 0) begin
        pb  = ~pb;
        evb = pb;
      end
      model(c, eva, evb);
    end
    for (int c = 3000; c < 3000 + lim + 20; c++) begin
      step();
      model(c, 1'b0, 1'b0);
    end
    mon_en = 1'b0;
    check("rand leftover expected results", exp_q.size(), 0);
    check("rand TMO count", tmo_cnt, exp_tmo);
    check("rand VALID with TMO", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
